// File: rtl/tipi_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tipi_reg_ctrl
//  Description : TIPI mailbox register controller. Synchronises TI bus and Pi
//                strobes into clk, sequences TI writes to TD/TC, serves TI
//                reads of RD/RC and a serial Pi shift port with sticky IRQ.
//                Optional debug LEDs enabled by defining TIPI_LED_DEBUG_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tipi_reg_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:15] ti_a,
  input  logic [7:0]  ti_data,
  input  logic        ti_memen,
  input  logic        ti_we,
  input  logic        ti_dbin,
  output logic [7:0]  ti_rdata,
  output logic        ti_rdata_oe,
  input  logic        rpi_sclk,
  input  logic        rpi_sdin,
  input  logic        rpi_le,
  input  logic [1:0]  rpi_sel,
  output logic        rpi_sdout,
  output logic        rpi_irq,
  input  logic        rpi_ack,
  output logic [7:0]  led
);

  localparam logic [15:0] c_addr_td = 16'h5FFF;
  localparam logic [15:0] c_addr_tc = 16'h5FFD;
  localparam logic [15:0] c_addr_rd = 16'h5FFB;
  localparam logic [15:0] c_addr_rc = 16'h5FF9;
  // Bit order {ack, le, sclk, dbin, we, memen}; active-low strobes idle high.
  localparam logic [5:0]  c_sync_rst = 6'b000011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_sync [SYNC_STAGES];
  logic [5:0]  w_sync;
  logic [2:0]  r_edge_d;
  logic [2:0]  w_rise;
  logic        w_memen, w_we, w_dbin;
  logic        w_sclk_rise, w_le_rise, w_ack_rise;
  logic        w_td_wr, w_tc_wr, w_rd_hit;
  logic [7:0]  r_td, r_tc, r_rd, r_rc;
  logic [7:0]  r_in_sr, r_out_sr;
  logic        r_irq;

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_memen     = w_sync[0];
  assign w_we        = w_sync[1];
  assign w_dbin      = w_sync[2];
  assign w_rise      = w_sync[5:3] & ~r_edge_d;
  assign w_sclk_rise = w_rise[0];
  assign w_le_rise   = w_rise[1];
  assign w_ack_rise  = w_rise[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= c_sync_rst;
      r_edge_d <= 3'b000;
    end else begin
      r_sync[0] <= {rpi_ack, rpi_le, rpi_sclk, ti_dbin, ti_we, ti_memen};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_edge_d <= w_sync[5:3];
    end
  end

  // One write per strobe: HOLD blocks re-capture until we deasserts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_we && !w_memen) w_state_nxt = CAPT;
      CAPT:    w_state_nxt = HOLD;
      HOLD:    if (w_we) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_td_wr = (r_state == CAPT) && (ti_a == c_addr_td);
  assign w_tc_wr = (r_state == CAPT) && (ti_a == c_addr_tc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_td  <= 8'h00;
      r_tc  <= 8'h00;
      r_irq <= 1'b0;
    end else begin
      if (w_td_wr) r_td <= ti_data;
      if (w_tc_wr) r_tc <= ti_data;
      if (w_tc_wr)         r_irq <= 1'b1;
      else if (w_ack_rise) r_irq <= 1'b0;
    end
  end

  assign w_rd_hit = !w_memen && w_dbin &&
                    ((ti_a == c_addr_rd) || (ti_a == c_addr_rc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ti_rdata    <= 8'h00;
      ti_rdata_oe <= 1'b0;
    end else begin
      ti_rdata_oe <= w_rd_hit;
      if (w_rd_hit) ti_rdata <= (ti_a == c_addr_rd) ? r_rd : r_rc;
    end
  end

  // Latch outranks shift; out_sr captures the pre-write register value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd     <= 8'h00;
      r_rc     <= 8'h00;
      r_in_sr  <= 8'h00;
      r_out_sr <= 8'h00;
    end else if (w_le_rise) begin
      case (rpi_sel)
        2'b00:   r_out_sr <= r_td;
        2'b01:   r_out_sr <= r_tc;
        2'b10:   r_out_sr <= r_rd;
        default: r_out_sr <= r_rc;
      endcase
      if (rpi_sel == 2'b10) r_rd <= r_in_sr;
      if (rpi_sel == 2'b11) r_rc <= r_in_sr;
    end else if (w_sclk_rise) begin
      r_in_sr  <= {r_in_sr[6:0], rpi_sdin};
      r_out_sr <= {r_out_sr[6:0], 1'b0};
    end
  end

  assign rpi_sdout = r_out_sr[7];
  assign rpi_irq   = r_irq;

`ifdef TIPI_LED_DEBUG_EN
  logic [7:0] r_led;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_led <= 8'h00;
    else        r_led <= {r_td[7:4], r_tc[3:0]};
  end
  assign led = r_led;
`else
  assign led = 8'h00;
`endif

endmodule
`default_nettype wire
